// File: rtl/arb_pkg.sv
// Shared types for the rotating-priority arbiter and its request clients.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } client_state_t;

    localparam int          ARB_N    = 4;
    localparam logic [3:0]  GNT_NONE = 4'b0000;
    localparam logic [3:0]  GNT_C0   = 4'b0001;
    localparam logic [3:0]  GNT_C1   = 4'b0010;
    localparam logic [3:0]  GNT_C2   = 4'b0100;
    localparam logic [3:0]  GNT_C3   = 4'b1000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; caller guards push/pop.
module sync_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     cnt_q;

    assign head_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

    always_ff @(posedge clock) begin
        if (push_i) mem_q[wr_q] <= push_data_i;
    end

    // Pointer width equals log2(DEPTH), so increments wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end
endmodule

// File: rtl/arb_req_client.sv
// Requester agent: queues jobs, requests the arbiter, drains up to BURST
// beats per grant tenure and idles req one cycle between tenures.
module arb_req_client
    import arb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int DATA_W       = 8,
    parameter int BURST        = 2,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_valid,
    input  logic [DATA_W-1:0]          push_data,
    output logic                       push_ready,
    output logic                       req,
    input  logic                       gnt,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       starve,
    output logic                       proto_err
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int BW = $clog2(BURST+1);
    localparam int SW = $clog2(STARVE_LIMIT+1);

    client_state_t     state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [SW-1:0]     stv_q, stv_d;
    logic              req_q, ov_q, stv_flag_q, perr_q;
    logic [DATA_W-1:0] od_q, head;
    logic              full, empty, push_en, pop, active;
    logic [CW-1:0]     cnt_next;

    sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push_en),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count)
    );

    assign push_ready = !full;
    assign push_en    = push_valid && !full;
    assign active     = (state_q == REQ) || (state_q == XFER);
    assign pop        = active && gnt && !empty;
    assign cnt_next   = count + CW'(push_en) - CW'(pop);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        stv_d   = stv_q;
        unique case (state_q)
            IDLE: if (count != '0) state_d = REQ;
            REQ: begin
                if (pop) begin
                    beat_d  = BW'(1);
                    stv_d   = '0;
                    state_d = (BURST > 1 && cnt_next != '0) ? XFER : RELEASE;
                end else if (!gnt && stv_q != SW'(STARVE_LIMIT)) begin
                    stv_d = stv_q + SW'(1);
                end
            end
            XFER: begin
                if (gnt) begin
                    beat_d = beat_q + BW'(1);
                    if (beat_d == BW'(BURST) || cnt_next == '0)
                        state_d = RELEASE;
                end else begin
                    beat_d  = '0;
                    state_d = REQ;
                end
            end
            RELEASE: state_d = (count != '0) ? REQ : IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            stv_q      <= '0;
            req_q      <= 1'b0;
            ov_q       <= 1'b0;
            od_q       <= '0;
            stv_flag_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            stv_q      <= stv_d;
            req_q      <= (state_d == REQ) || (state_d == XFER);
            ov_q       <= pop;
            if (pop) od_q <= head;
            stv_flag_q <= (stv_d == SW'(STARVE_LIMIT));
            perr_q     <= perr_q | (gnt & ~req_q);
        end
    end

    assign req       = req_q;
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign starve    = stv_flag_q;
    assign proto_err = perr_q;
endmodule

// File: tb/tb_arb_req_client.sv
// Directed bench for arb_req_client (DEPTH=4, DATA_W=8, BURST=2, LIMIT=15).
module tb_arb_req_client;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       push_valid = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       push_ready;
    logic       req;
    logic       gnt = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       starve;
    logic       proto_err;

    int nchk  = 0;
    int nfail = 0;

    arb_req_client #(
        .DEPTH(4), .DATA_W(8), .BURST(2), .STARVE_LIMIT(15)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .req        (req),
        .gnt        (gnt),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .count      (count),
        .starve     (starve),
        .proto_err  (proto_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        push_valid = 1'b0;
        gnt = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic push(input logic [7:0] d);
        push_valid = 1'b1;
        push_data = d;
    endtask

    initial begin
        step();
        chk("rst_req", req, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_od", out_data, 0);
        chk("rst_cnt", count, 0);
        chk("rst_starve", starve, 0);
        chk("rst_perr", proto_err, 0);
        chk("rst_pready", push_ready, 1);
        reset = 1'b1;

        // Queue two jobs, never grant: request then starvation
        push(8'hA5); step();
        chk("t1_cnt1", count, 1);
        chk("t1_req_e1", req, 0);
        push(8'h3C); step();
        push_valid = 1'b0;
        chk("t1_cnt2", count, 2);
        chk("t1_req_e2", req, 1);
        repeat (14) step();
        chk("t1_starve14", starve, 0);
        step();
        chk("t1_starve15", starve, 1);
        gnt = 1'b1; step();
        chk("t1_ov", out_valid, 1);
        chk("t1_od", out_data, 8'hA5);
        chk("t1_starve_clr", starve, 0);

        // Burst of two, release gap, third beat on next grant
        do_reset();
        push(8'h11); step();
        push(8'h22); step();
        push(8'h33); step();
        push_valid = 1'b0;
        chk("t2_cnt3", count, 3);
        gnt = 1'b1; step();
        chk("t2_b1_ov", out_valid, 1);
        chk("t2_b1_od", out_data, 8'h11);
        chk("t2_b1_req", req, 1);
        step();
        chk("t2_b2_od", out_data, 8'h22);
        chk("t2_b2_ov", out_valid, 1);
        chk("t2_rel_req", req, 0);
        chk("t2_b2_cnt", count, 1);
        gnt = 1'b0; step();
        chk("t2_rel_ov", out_valid, 0);
        chk("t2_rereq", req, 1);
        gnt = 1'b1; step();
        chk("t2_b3_od", out_data, 8'h33);
        chk("t2_b3_req", req, 0);
        chk("t2_b3_cnt", count, 0);
        gnt = 1'b0; step();
        chk("t2_idle_req", req, 0);
        chk("t2_hold_od", out_data, 8'h33);
        chk("t2_perr", proto_err, 0);

        // Preemption after first beat
        do_reset();
        push(8'h44); step();
        push(8'h55); step();
        push_valid = 1'b0;
        gnt = 1'b1; step();
        chk("t3_b1_od", out_data, 8'h44);
        gnt = 1'b0; step();
        chk("t3_pre_req", req, 1);
        chk("t3_pre_ov", out_valid, 0);
        chk("t3_pre_cnt", count, 1);
        gnt = 1'b1; step();
        chk("t3_b2_ov", out_valid, 1);
        chk("t3_b2_od", out_data, 8'h55);
        chk("t3_b2_req", req, 0);

        // Full drop, simultaneous push/pop, order preserved
        do_reset();
        push(8'h01); step();
        push(8'h02); step();
        push(8'h03); step();
        push(8'h04); step();
        chk("t4_full_cnt", count, 4);
        chk("t4_pready0", push_ready, 0);
        push(8'hFF); step();
        push_valid = 1'b0;
        chk("t4_drop_cnt", count, 4);
        gnt = 1'b1; step();
        chk("t4_p1", out_data, 8'h01);
        chk("t4_cnt3", count, 3);
        gnt = 1'b0; step();
        gnt = 1'b1; push(8'h05); step();
        push_valid = 1'b0;
        chk("t4_pp_cnt", count, 3);
        chk("t4_p2", out_data, 8'h02);
        step();
        chk("t4_p3", out_data, 8'h03);
        gnt = 1'b0; step();
        gnt = 1'b1; step();
        chk("t4_p4", out_data, 8'h04);
        step();
        chk("t4_p5", out_data, 8'h05);
        chk("t4_end_cnt", count, 0);
        gnt = 1'b0;

        // Grant while idle: sticky protocol error, no beat
        do_reset();
        gnt = 1'b1; step();
        chk("t5_perr", proto_err, 1);
        chk("t5_ov", out_valid, 0);
        gnt = 1'b0; step();
        chk("t5_perr_sticky", proto_err, 1);

        // Asynchronous reset mid-transfer
        do_reset();
        push(8'h66); step();
        push(8'h77); step();
        push_valid = 1'b0;
        gnt = 1'b1; step();
        chk("t6_xfer_req", req, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_ar_req", req, 0);
        chk("t6_ar_ov", out_valid, 0);
        chk("t6_ar_cnt", count, 0);
        gnt = 1'b0;
        #1 reset = 1'b1;
        step();
        chk("t6_idle_req", req, 0);
        chk("t6_idle_cnt", count, 0);

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end
endmodule

// File: doc/arb_req_client.md
Name: arb_req_client

Overview:
- Requester-side agent for the rotating-priority grant arbiter.
- Buffers local jobs in a small FIFO and raises `req` while work is pending.
- On each `gnt` cycle it drains one entry onto a registered output bus, up to BURST entries per grant tenure.
- Drops `req` for one cycle between tenures so the rotating arbiter can advance.
- Instantiated once per arbiter request line (4 per rps4-style arbiter).

Parameters:
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- DATA_W, 8: job word width.
- BURST, 2: maximum entries drained per grant tenure; at least 1.
- STARVE_LIMIT, 15: consecutive ungranted REQ cycles before `starve` asserts.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low (0 = reset asserted).
- push_valid, input, 1: enqueue strobe.
- push_data, input, DATA_W: word to enqueue.
- push_ready, output, 1: FIFO not full (combinational from occupancy).
- req, output, 1: registered request to arbiter.
- gnt, input, 1: this client's grant bit from arbiter.
- out_valid, output, 1: registered; one beat transferred.
- out_data, output, DATA_W: registered; beat payload.
- count, output, $clog2(DEPTH+1): current FIFO occupancy.
- starve, output, 1: registered starvation flag.
- proto_err, output, 1: sticky; `gnt` seen while `req`=0.

Behaviour:
- Reset (reset=0, async): state=IDLE; req=0; out_valid=0; out_data=0; count=0; FIFO pointers=0; starve=0; proto_err=0; beat and starve counters=0. Reset mid-transfer discards all FIFO contents.
- Push: accepted on an edge with push_valid=1 and count<DEPTH. push_valid while full is dropped silently. Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- Pop: occurs only on an edge where state is REQ or XFER, gnt=1 and count>0. That edge sets out_data<=head and out_valid<=1, so latency is gnt to out_valid = 1 cycle. out_valid=0 on every other edge; out_data holds its last value.
- FSM states: IDLE, REQ, XFER, RELEASE. req=1 in REQ and XFER only, registered so it tracks state.
  - IDLE: move to REQ when count>0 (including an entry just pushed, visible next cycle).
  - REQ, gnt=0: stay; increment starve counter, saturating at STARVE_LIMIT.
  - REQ, gnt=1: pop; beat_cnt<=1; starve counter<=0. Go to XFER if BURST>1 and count after pop >0, else RELEASE.
  - XFER, gnt=1: pop; beat_cnt++. Go to RELEASE when beat_cnt reaches BURST or the FIFO empties.
  - XFER, gnt=0 (preempted): back to REQ; beat_cnt<=0.
  - RELEASE: req=0 for exactly one cycle, then REQ if count>0, else IDLE.
- starve: 1 whenever the starve counter equals STARVE_LIMIT; cleared on the next grant or on reset.
- proto_err: set when gnt=1 at an edge while req=0 (IDLE or RELEASE); cleared only by reset. Such a grant pops nothing.
- Arithmetic: beat_cnt width $clog2(BURST+1); starve counter width $clog2(STARVE_LIMIT+1); all counters unsigned.
- No combinational path from gnt to req.

Decomposition:
- Shared package `arb_pkg`: `client_state_t` enum (IDLE, REQ, XFER, RELEASE); grant encoding constants reused by the arbiter.
- Sub-module `sync_fifo`: DEPTH×DATA_W storage with push, pop, full, empty and count. The FSM, beat counter and starve logic stay in the top module.

Test Plan:
- Reset, then push A5, 3C with gnt=0 → req=1 from cycle 2; count=2; starve=1 after 15 ungranted cycles.
- Hold gnt=1 continuously with 3 entries (11, 22, 33), BURST=2 → out 11 and 22 on consecutive cycles; req=0 for 1 cycle; then req=1; 33 delivered on the next grant.
- Drop gnt after the first beat (preemption) → state returns to REQ; req stays 1; the remaining entry pops on the next gnt with beat_cnt restarted.
- Fill to 4 entries, push_valid=1 with data FF → push_ready=0, FF dropped, count=4. Pop and push on the same cycle at count=3 → count stays 3.
- gnt=1 while IDLE and empty → proto_err=1 and stays 1; no out_valid.
- Assert reset low mid-XFER → req, out_valid and count go to 0 immediately (asynchronously); IDLE after release.
